// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // An ID field is never narrower than one bit, even for a single requester.
    function automatic int unsigned id_w(input int unsigned n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake plus FIFO write-side signals shared by the arbiter and its neighbours.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter int unsigned NUM_REQ    = 2
);
    localparam int unsigned IDW = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]            REQ_VALID;
    logic [NUM_REQ*data_width-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]            REQ_LAST;
    logic [NUM_REQ-1:0]            REQ_READY;
    logic                          FULL;
    logic                          W_INC;
    logic [data_width-1:0]         WR_DATA;
    logic [IDW-1:0]                GRANT_ID;
    logic                          BUSY;
    logic                          BURST_CUT;

    modport master (
        output REQ_VALID, REQ_DATA, REQ_LAST, FULL,
        input  REQ_READY, W_INC, WR_DATA, GRANT_ID, BUSY, BURST_CUT
    );

    modport slave (
        input  REQ_VALID, REQ_DATA, REQ_LAST, FULL,
        output REQ_READY, W_INC, WR_DATA, GRANT_ID, BUSY, BURST_CUT
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping at NUM_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDW     = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_ptr,
    output logic [IDW-1:0]     o_idx,
    output logic               o_found
);
    int unsigned w_j;

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_j     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_j = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_found && i_req[w_j]) begin
                o_found = 1'b1;
                o_idx   = IDW'(w_j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Frame-aware round-robin arbiter driving the async FIFO write port through a 1-entry output register.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic           CLK,
    input  logic           RST,
    fifo_wr_arbiter_if.slave bus
);
    localparam int unsigned IDW = id_w(NUM_REQ);
    localparam int unsigned CW  = clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);

    arb_state_t            r_state;
    logic [IDW-1:0]        r_owner;
    logic [IDW-1:0]        r_ptr;
    logic [CW-1:0]         r_cnt;
    logic                  r_out_vld;
    logic [data_width-1:0] r_out_data;
    logic                  r_cut;

    logic [IDW-1:0]        w_pick;
    logic                  w_found;
    logic                  w_own_vld;
    logic                  w_own_last;
    logic [data_width-1:0] w_own_data;
    logic                  w_grant;
    logic                  w_space;
    logic                  w_accept;
    logic                  w_winc;
    logic [IDW-1:0]        w_next_ptr;
    logic [NUM_REQ-1:0]    w_ready;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .i_req   (bus.REQ_VALID),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    always_comb begin
        w_own_vld  = 1'b0;
        w_own_last = 1'b0;
        w_own_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_owner == IDW'(i)) begin
                w_own_vld  = bus.REQ_VALID[i];
                w_own_last = bus.REQ_LAST[i];
                w_own_data = bus.REQ_DATA[i*data_width +: data_width];
            end
        end
    end

    // A beat may enter the output register only if it is empty or draining this cycle.
    assign w_grant    = (r_state == GRANT);
    assign w_space    = ~r_out_vld | ~bus.FULL;
    assign w_accept   = w_grant & w_space & w_own_vld;
    assign w_winc     = r_out_vld & ~bus.FULL;
    assign w_next_ptr = (r_owner == IDW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_ready[i] = w_grant & w_space & (r_owner == IDW'(i));
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_cut      <= 1'b0;
        end else begin
            r_cut <= 1'b0;
            if (w_accept) begin
                r_out_vld  <= 1'b1;
                r_out_data <= w_own_data;
            end else if (w_winc) begin
                r_out_vld  <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= GRANT;
                        r_owner <= w_pick;
                        r_cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (w_accept) begin
                        if (w_own_last || (r_cnt == CAP)) begin
                            r_state <= IDLE;
                            r_ptr   <= w_next_ptr;
                            r_cut   <= ~w_own_last;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.REQ_READY = w_ready;
    assign bus.W_INC     = w_winc;
    assign bus.WR_DATA   = r_out_data;
    assign bus.GRANT_ID  = r_owner;
    assign bus.BUSY      = w_grant;
    assign bus.BURST_CUT = r_cut;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scenarios plus randomized traffic checked against a transaction-level arbiter model.
module tb_fifo_wr_arbiter;
    localparam int NR = 3;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.data_width(8), .NUM_REQ(NR)) bus ();

    fifo_wr_arbiter #(
        .data_width (8),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Producers: per-requester frame queues of {last, data}
    logic [8:0] q [NR][$];
    logic [8:0] curw [NR];
    bit         pres [NR];
    int         stall [NR];
    int         gapreq [NR];
    int         acc_cnt [NR];
    int         rnd_pct = 0;
    logic       full = 1'b0;

    // Reference model: grant owner, rr pointer, beats in grant, pending write queue
    bit         m_busy;
    int         m_owner;
    int         m_ptr;
    int         m_beats;
    bit         m_cut;
    logic [7:0] mq [$];

    // Observation logs for directed checks
    logic [7:0] wlog [$];
    int         wcyc [$];
    int         glog [$];
    int         cuts;
    bit         prev_busy;
    logic       last_winc;
    logic       last_rdy;
    logic [7:0] ew [$];
    int         eg [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.REQ_VALID[i]       = pres[i];
            bus.REQ_LAST[i]        = pres[i] & curw[i][8];
            bus.REQ_DATA[i*8 +: 8] = curw[i][7:0];
        end
        bus.FULL = full;
    endtask

    task automatic produce(input int acc);
        for (int i = 0; i < NR; i++) begin
            if (acc == i) begin
                pres[i]   = 1'b0;
                stall[i]  = gapreq[i];
                gapreq[i] = 0;
            end
            if (!pres[i]) begin
                if (stall[i] > 0) stall[i]--;
                else if (q[i].size() > 0 && (rnd_pct == 0 || int'($urandom_range(99)) < rnd_pct)) begin
                    curw[i] = q[i].pop_front();
                    pres[i] = 1'b1;
                end
            end
        end
        drive();
    endtask

    task automatic clear_logs();
        wlog.delete(); wcyc.delete(); glog.delete();
        cuts = 0;
        for (int i = 0; i < NR; i++) acc_cnt[i] = 0;
    endtask

    task automatic step();
        logic [NR-1:0] er;
        bit ewi;
        int acc;
        int j;
        @(negedge clk);
        er = '0;
        if (m_busy && (mq.size() == 0 || !full)) er[m_owner] = 1'b1;
        ewi = (mq.size() > 0) && !full;
        chk("REQ_READY", 32'(bus.REQ_READY), 32'(er));
        chk("W_INC", 32'(bus.W_INC), 32'(ewi));
        if (ewi) chk("WR_DATA", 32'(bus.WR_DATA), 32'(mq[0]));
        chk("BUSY", 32'(bus.BUSY), 32'(m_busy));
        if (m_busy) chk("GRANT_ID", 32'(bus.GRANT_ID), m_owner);
        chk("BURST_CUT", 32'(bus.BURST_CUT), 32'(m_cut));
        last_winc = bus.W_INC;
        last_rdy  = |bus.REQ_READY;
        if (bus.W_INC === 1'b1) begin wlog.push_back(bus.WR_DATA); wcyc.push_back(cyc); end
        if (bus.BURST_CUT === 1'b1) cuts++;
        if (bus.BUSY === 1'b1 && !prev_busy) glog.push_back(int'(bus.GRANT_ID));
        prev_busy = (bus.BUSY === 1'b1);

        acc = -1;
        if (m_busy && er[m_owner] && pres[m_owner]) acc = m_owner;
        if (ewi) void'(mq.pop_front());
        m_cut = 1'b0;
        if (!m_busy) begin
            for (int k = 0; k < NR; k++) begin
                j = (m_ptr + k) % NR;
                if (pres[j]) begin
                    m_busy = 1'b1; m_owner = j; m_beats = 0;
                    break;
                end
            end
        end else if (acc >= 0) begin
            acc_cnt[acc]++;
            mq.push_back(curw[acc][7:0]);
            m_beats++;
            if (curw[acc][8] || m_beats == MB) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % NR;
                m_cut  = !curw[acc][8];
            end
        end
        @(posedge clk); #1;
        cyc++;
        produce(acc);
    endtask

    // Reset may be applied mid-cycle; outputs are checked before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NR; i++) begin
            q[i].delete(); pres[i] = 1'b0; stall[i] = 0; gapreq[i] = 0; curw[i] = '0;
        end
        m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_beats = 0; m_cut = 1'b0;
        mq.delete();
        prev_busy = 1'b0;
        drive();
        chk("rst BUSY", 32'(bus.BUSY), 0);
        chk("rst W_INC", 32'(bus.W_INC), 0);
        chk("rst READY", 32'(bus.REQ_READY), 0);
        chk("rst GRANT_ID", 32'(bus.GRANT_ID), 0);
        chk("rst BURST_CUT", 32'(bus.BURST_CUT), 0);
        chk("rst WR_DATA", 32'(bus.WR_DATA), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic bit active();
        bit a;
        a = m_busy || (mq.size() > 0);
        for (int i = 0; i < NR; i++) a = a || pres[i] || (q[i].size() > 0) || (stall[i] > 0);
        return a;
    endfunction

    task automatic run_until_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (active() && n < budget) begin step(); n++; end
        chk(tag, 32'(n < budget), 1);
        step();
    endtask

    task automatic chk_wlog(input string tag);
        chk(tag, wlog.size(), ew.size());
        for (int i = 0; i < ew.size(); i++)
            chk(tag, (i < wlog.size()) ? 32'(wlog[i]) : 32'hFFFF_FFFF, 32'(ew[i]));
    endtask

    task automatic chk_glog(input string tag);
        chk(tag, glog.size(), eg.size());
        for (int i = 0; i < eg.size(); i++)
            chk(tag, (i < glog.size()) ? glog[i] : -1, eg[i]);
    endtask

    initial begin
        int t0, n, wsum, rsum, gen_cnt, len;

        do_reset();

        // Single 3-beat frame: writes land 2,3,4 cycles after VALID
        clear_logs();
        q[0] = {9'h0A1, 9'h0A2, 9'h1A3};
        t0 = cyc;
        produce(-1);
        run_until_idle("t1 timeout", 40);
        ew = {8'hA1, 8'hA2, 8'hA3};
        chk_wlog("t1 data");
        chk("t1 wcyc0", (wcyc.size() > 0) ? wcyc[0] : -1, t0 + 2);
        chk("t1 wcyc2", (wcyc.size() > 2) ? wcyc[2] : -1, t0 + 4);
        eg = {0};
        chk_glog("t1 grant");

        // Contention from reset with 1-beat frames
        do_reset();
        clear_logs();
        q[0] = {9'h110, 9'h111};
        q[1] = {9'h120, 9'h121};
        produce(-1);
        run_until_idle("t2 timeout", 40);
        ew = {8'h10, 8'h20, 8'h11, 8'h21};
        chk_wlog("t2 order");
        eg = {0, 1, 0, 1};
        chk_glog("t2 grant");

        // Fairness cap at MAX_BURST beats
        do_reset();
        clear_logs();
        q[0] = {9'h0A0, 9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4, 9'h1A5};
        q[1] = {9'h0B0, 9'h1B1};
        produce(-1);
        run_until_idle("t3 timeout", 60);
        ew = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hA4, 8'hA5};
        chk_wlog("t3 order");
        chk("t3 cuts", cuts, 1);
        eg = {0, 1, 0};
        chk_glog("t3 grant");

        // FULL stall with a beat held in the output register
        clear_logs();
        full = 1'b1;
        q[0] = {9'h0C0, 9'h0C1, 9'h1C2};
        produce(-1);
        n = 0;
        while (mq.size() == 0 && n < 20) begin step(); n++; end
        chk("t4 hold timeout", 32'(n < 20), 1);
        wsum = 0; rsum = 0;
        repeat (5) begin
            step();
            wsum += int'(last_winc);
            rsum += int'(last_rdy);
        end
        chk("t4 stall winc", wsum, 0);
        chk("t4 stall ready", rsum, 0);
        full = 1'b0;
        drive();
        run_until_idle("t4 timeout", 40);
        ew = {8'hC0, 8'hC1, 8'hC2};
        chk_wlog("t4 data");

        // Reset during beat 2 of 4, then a fresh three-way contention
        clear_logs();
        q[0] = {9'h0D0, 9'h0D1, 9'h0D2, 9'h1D3};
        produce(-1);
        n = 0;
        while (acc_cnt[0] < 1 && n < 20) begin step(); n++; end
        chk("t5 beat timeout", 32'(n < 20), 1);
        #2;
        do_reset();
        clear_logs();
        wsum = 0;
        repeat (4) begin step(); wsum += int'(last_winc); end
        chk("t5 quiet", wsum, 0);
        q[0] = {9'h1E0};
        q[1] = {9'h1E1};
        q[2] = {9'h1E2};
        produce(-1);
        run_until_idle("t5 timeout", 40);
        eg = {0, 1, 2};
        chk_glog("t5 grant");
        ew = {8'hE0, 8'hE1, 8'hE2};
        chk_wlog("t5 data");

        // Owner drops VALID for 3 cycles mid-frame while req1 waits
        clear_logs();
        q[0] = {9'h0F0, 9'h0F1, 9'h1F2};
        q[1] = {9'h1F3};
        gapreq[0] = 3;
        produce(-1);
        run_until_idle("t6 timeout", 40);
        ew = {8'hF0, 8'hF1, 8'hF2, 8'hF3};
        chk_wlog("t6 order");
        eg = {0, 1};
        chk_glog("t6 grant");

        // Randomized frames, gaps and FULL
        do_reset();
        clear_logs();
        rnd_pct = 70;
        gen_cnt = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (q[i].size() == 0 && !pres[i] && $urandom_range(7) == 0) begin
                    len = int'($urandom_range(1, 6));
                    for (int b = 0; b < len; b++)
                        q[i].push_back({(b == len - 1), 8'($urandom)});
                    gen_cnt += len;
                end
            end
            full = ($urandom_range(3) == 0);
            drive();
            step();
        end
        full = 1'b0;
        rnd_pct = 0;
        drive();
        run_until_idle("rnd drain timeout", 400);
        chk("rnd count", wlog.size(), gen_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
